// File: rtl/fifo_rd_stream.sv
// Async-FIFO read-side adapter: registered pops into a DEPTH-entry skid buffer, valid/ready out.
// Latency 2 cycles pop-to-valid; credit from registered occupancy only, so a stalled sink halts pops.
module fifo_rd_stream #(
  parameter int DW    = 8,
  parameter int DEPTH = 3
) (
  input  logic          clk_rd,
  input  logic          rrst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          fifo_rd_en,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          clr,
  output logic [15:0]   byte_cnt,
  output logic [DW-1:0] xor_sum
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          inflight;
  logic          run;
  logic [CW:0]   occ;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // run holds off pops until the first edge after reset release
  assign occ        = {1'b0, cnt} + {{CW{1'b0}}, inflight};
  assign fifo_rd_en = run && !fifo_empty && (occ < (CW+1)'(DEPTH));
  assign push       = inflight;
  assign out_valid  = (cnt != '0);
  assign out_data   = mem[rd_ptr];
  assign pop        = out_valid && out_ready;

  always_ff @(posedge clk_rd or posedge rrst) begin
    if (rrst) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= fifo_rd_en;
      if (push) begin
        mem[wr_ptr] <= fifo_rd_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (!push && pop) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk_rd or posedge rrst) begin
    if (rrst) begin
      byte_cnt <= '0;
      xor_sum  <= '0;
    end else if (clr) begin
      byte_cnt <= pop ? 16'd1 : 16'd0;
      xor_sum  <= pop ? out_data : '0;
    end else if (pop) begin
      byte_cnt <= byte_cnt + 16'd1;
      xor_sum  <= xor_sum ^ out_data;
    end
  end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The module SHALL have parameter DW, default 8, data width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 3, number of skid-buffer entries; minimum legal value 3.
REQ-003 The module SHALL have port clk_rd  input  1  read-domain clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rrst  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port fifo_empty  input  1  empty flag from the upstream async FIFO read side.
REQ-006 The module SHALL have port fifo_rd_data  input  DW  upstream FIFO read data.
REQ-007 The module SHALL have port fifo_rd_en  output  1  pop request to the upstream FIFO.
REQ-008 The module SHALL have port out_data  output  DW  downstream stream data.
REQ-009 The module SHALL have port out_valid  output  1  downstream data valid.
REQ-010 The module SHALL have port out_ready  input  1  downstream ready.
REQ-011 The module SHALL have port clr  input  1  synchronous clear of statistics.
REQ-012 The module SHALL have port byte_cnt  output  16  count of words delivered downstream.
REQ-013 The module SHALL have port xor_sum  output  DW  running XOR of words delivered downstream.

Function
REQ-014 The upstream FIFO read SHALL be treated as registered: fifo_rd_en high in cycle T with fifo_empty low -> fifo_rd_data valid in cycle T+1 only.
REQ-015 fifo_rd_en SHALL be combinational: high iff fifo_empty==0 and (cnt + inflight) < DEPTH, where cnt = buffered entries (0..DEPTH) and inflight = 1 if fifo_rd_en was high last cycle.
REQ-016 fifo_rd_en SHALL never be high while fifo_empty is high.
REQ-017 Same-cycle downstream pops SHALL NOT grant credit; credit is computed from registered cnt and inflight only.
REQ-018 The word returned in cycle T+1 SHALL be written into the buffer at the end of T+1; out_valid SHALL be high from cycle T+2 (first-word latency 2 cycles from fifo_rd_en).
REQ-019 The buffer SHALL be a circular queue, DEPTH entries, separate write/read pointers wrapping DEPTH-1 -> 0; word order preserved.
REQ-020 out_valid SHALL equal (cnt != 0); out_data SHALL be the head entry.
REQ-021 Handshake SHALL occur when out_valid && out_ready; head pointer advances, cnt decrements.
REQ-022 Simultaneous arrival and handshake SHALL leave cnt unchanged and both pointers advance.
REQ-023 While out_valid && !out_ready, out_data SHALL remain stable and out_valid SHALL stay high.
REQ-024 With continuous non-empty FIFO and out_ready held high, steady-state throughput SHALL be one word per cycle.
REQ-025 Buffer overflow SHALL be impossible by construction; cnt SHALL never exceed DEPTH.
REQ-026 On each handshake byte_cnt SHALL increment by 1, wrapping 16'hFFFF -> 0, and xor_sum SHALL become xor_sum ^ out_data.
REQ-027 clr high SHALL set byte_cnt to 0 and xor_sum to 0; with a simultaneous handshake the result SHALL be byte_cnt=1, xor_sum=out_data.
REQ-028 clr SHALL NOT affect buffer contents, pointers, inflight or the stream outputs.

Reset
REQ-029 rrst high SHALL immediately clear cnt, pointers, inflight, byte_cnt, xor_sum; out_valid=0, fifo_rd_en=0, out_data=0 (buffer storage also cleared).
REQ-030 Reset mid-operation SHALL drop any in-flight and buffered words; no word delivered after reset deassertion originates from before it.
REQ-031 After rrst deasserts, fifo_rd_en SHALL assert no earlier than the first rising edge after release, subject to REQ-015.

Verification
REQ-032 Reset then FIFO holding 0xA5,0x3C, out_ready=1 -> fifo_rd_en high in cycles 0,1; out_data 0xA5 in cycle 2, 0x3C in cycle 3; byte_cnt=2, xor_sum=0x99.
REQ-033 Continuous non-empty FIFO, out_ready=0 -> exactly 3 pops, fifo_rd_en then stays low, out_data holds first word; raise out_ready -> 3 words in order, one per cycle, then pops resume.
REQ-034 FIFO going empty mid-burst -> fifo_rd_en drops same cycle as fifo_empty rises; no duplicate or missing words.
REQ-035 clr pulsed in the same cycle as a handshake of 0x7E with byte_cnt=5 -> byte_cnt=1, xor_sum=0x7E.
REQ-036 rrst asserted with 2 buffered words and 1 in flight -> out_valid=0 immediately; after release first delivered word is the next FIFO word, byte_cnt counts from 0.
REQ-037 65536 handshakes -> byte_cnt wraps to 0.
